// File: rtl/fifo_rd_ctrl_pkg.sv
// Shared definitions for the FIFO read-side controller and its skid buffer.
package fifo_rd_ctrl_pkg;

    // Default geometry of the team's FIFO memory block
    localparam int unsigned FIFO_DEPTH  = 8;
    localparam int unsigned FIFO_DATA_W = 10;

    // Occupancy count width: holds 0..depth+2
    localparam int unsigned COUNT_W = 4;

    // Error vector layout
    localparam int unsigned ERR_W   = 2;
    localparam int unsigned ERR_OVF = 0;
    localparam int unsigned ERR_UNF = 1;

    // Output skid buffer geometry
    localparam int unsigned SKID_DEPTH = 2;
    localparam int unsigned OCC_W      = 2;

endpackage : fifo_rd_ctrl_pkg

// File: rtl/fifo_skid_buf.sv
// Two-entry valid/ready output buffer. Captures returning memory words at the
// tail and presents the head downstream; a pop promotes the second slot to the
// head in the same edge so back-to-back pops see no bubble.
module fifo_skid_buf
    import fifo_rd_ctrl_pkg::*;
#(
    parameter int unsigned data_width = FIFO_DATA_W
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  capture,
    input  logic [data_width-1:0] cap_data,
    input  logic                  pop,
    output logic [data_width-1:0] head_data,
    output logic                  valid,
    output logic [OCC_W-1:0]      occupancy
);

    localparam logic [OCC_W-1:0] OCC_ZERO = OCC_W'(0);
    localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(SKID_DEPTH);

    logic [data_width-1:0] tail_data;

    // Slot bookkeeping: capture appends at the tail, pop advances the head
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            head_data <= '0;
            tail_data <= '0;
            occupancy <= OCC_ZERO;
            valid     <= 1'b0;
        end else begin
            case ({capture, pop})
                2'b10: begin
                    if (occupancy == OCC_ZERO) begin
                        head_data <= cap_data;
                    end else begin
                        tail_data <= cap_data;
                    end
                    occupancy <= occupancy + OCC_ONE;
                    valid     <= 1'b1;
                end
                2'b01: begin
                    if (occupancy == OCC_FULL) begin
                        head_data <= tail_data;
                    end
                    occupancy <= occupancy - OCC_ONE;
                    valid     <= (occupancy == OCC_FULL);
                end
                2'b11: begin
                    // Occupancy is unchanged; the new word lands behind the survivor
                    if (occupancy == OCC_FULL) begin
                        head_data <= tail_data;
                        tail_data <= cap_data;
                    end else begin
                        head_data <= cap_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule : fifo_skid_buf

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for the 8-entry FIFO memory block. Mirrors the writer's
// push stream to track memory occupancy, issues the memory read strobe, absorbs
// the 1-cycle read latency in a 2-entry skid buffer and produces the status
// flags used by the writer for flow control.
// Build option: define FIFO_RD_CTRL_ERR_EN to build sticky overflow/underflow
// detection on error[]; otherwise error is tied to zero.
module fifo_rd_ctrl
    import fifo_rd_ctrl_pkg::*;
#(
    parameter int unsigned data_width = FIFO_DATA_W,
    parameter int unsigned depth      = FIFO_DEPTH,
    parameter int unsigned af_margin  = 1,
    parameter int unsigned ae_margin  = 1
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  push,
    input  logic [data_width-1:0] mem_data_in,
    output logic                  rdmem_enable,
    output logic [data_width-1:0] data_out,
    output logic                  valid,
    input  logic                  ready,
    output logic [COUNT_W-1:0]    fifo_count,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ERR_W-1:0]      error
);

    localparam int unsigned       PTR_W   = $clog2(depth);
    localparam logic [COUNT_W-1:0] DEPTH_C = COUNT_W'(depth);
    localparam logic [COUNT_W-1:0] AF_LVL  = COUNT_W'(depth - af_margin);
    localparam logic [COUNT_W-1:0] AE_LVL  = COUNT_W'(ae_margin);

    logic [COUNT_W-1:0] mem_count;
    logic               inflight;
    logic [PTR_W-1:0]   rd_ptr;
    logic [OCC_W-1:0]   buf_occ;

    logic               pop_c;
    logic               push_ok_c;
    logic [OCC_W-1:0]   credits_c;
    logic [OCC_W-1:0]   occ_nxt_c;
    logic [COUNT_W-1:0] mem_count_nxt_c;
    logic [COUNT_W-1:0] fifo_count_nxt_c;

    // Read issue and next-state occupancy arithmetic
    always_comb begin
        pop_c            = valid & ready;
        push_ok_c        = push & (mem_count != DEPTH_C);
        credits_c        = OCC_W'(SKID_DEPTH) - buf_occ - OCC_W'(inflight);
        rdmem_enable     = (mem_count != '0) & ((credits_c != '0) | pop_c);
        occ_nxt_c        = buf_occ + OCC_W'(inflight) - OCC_W'(pop_c);
        mem_count_nxt_c  = mem_count;
        if (push_ok_c && !rdmem_enable) begin
            mem_count_nxt_c = mem_count + COUNT_W'(1);
        end else if (!push_ok_c && rdmem_enable) begin
            mem_count_nxt_c = mem_count - COUNT_W'(1);
        end
        fifo_count_nxt_c = mem_count_nxt_c + COUNT_W'(rdmem_enable) + COUNT_W'(occ_nxt_c);
    end

    // Counts, in-flight tracking, read index and registered status flags
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            mem_count    <= '0;
            inflight     <= 1'b0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            mem_count    <= mem_count_nxt_c;
            inflight     <= rdmem_enable;
            rd_ptr       <= rd_ptr + PTR_W'(rdmem_enable);
            fifo_count   <= fifo_count_nxt_c;
            empty        <= (fifo_count_nxt_c == '0);
            full         <= (mem_count_nxt_c == DEPTH_C);
            almost_full  <= (mem_count_nxt_c >= AF_LVL);
            almost_empty <= (fifo_count_nxt_c <= AE_LVL);
        end
    end

    // Returning read data is captured only while its read is still in flight
    fifo_skid_buf #(
        .data_width (data_width)
    ) u_skid (
        .clk        (clk),
        .reset_L    (reset_L),
        .capture    (inflight),
        .cap_data   (mem_data_in),
        .pop        (pop_c),
        .head_data  (data_out),
        .valid      (valid),
        .occupancy  (buf_occ)
    );

`ifdef FIFO_RD_CTRL_ERR_EN
    logic [ERR_W-1:0] err_q;

    // Sticky overflow (push while full) and underflow (strobe on empty queue)
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            err_q <= '0;
        end else begin
            if (push && (mem_count == DEPTH_C)) begin
                err_q[ERR_OVF] <= 1'b1;
            end
            if (ready && !valid && (fifo_count == '0)) begin
                err_q[ERR_UNF] <= 1'b1;
            end
        end
    end

    assign error = err_q;
`else
    assign error[ERR_OVF] = 1'b0;
    assign error[ERR_UNF] = 1'b0;
`endif

endmodule : fifo_rd_ctrl

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: behavioural FIFO memory, per-cycle vector table for
// the first-word and fill sequences, scoreboard for every delivered word.
`timescale 1ns/1ps
module tb_fifo_rd_ctrl;

    localparam int unsigned DW = 10;
`ifdef FIFO_RD_CTRL_ERR_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_L;
    logic          push;
    logic          ready;
    logic [DW-1:0] mem_data_in = '0;
    logic          rdmem_enable;
    logic [DW-1:0] data_out;
    logic          valid;
    logic [3:0]    fifo_count;
    logic          empty;
    logic          full;
    logic          almost_full;
    logic          almost_empty;
    logic [1:0]    error;

    always #5 clk = ~clk;

    fifo_rd_ctrl dut (
        .clk          (clk),
        .reset_L      (reset_L),
        .push         (push),
        .mem_data_in  (mem_data_in),
        .rdmem_enable (rdmem_enable),
        .data_out     (data_out),
        .valid        (valid),
        .ready        (ready),
        .fifo_count   (fifo_count),
        .empty        (empty),
        .full         (full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .error        (error)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural 8-entry memory: write on push when not full, data one cycle after read
    logic [DW-1:0] mem [8];
    logic [2:0]    wptr;
    logic [2:0]    rptr;
    int            mcnt;
    logic [DW-1:0] wdata;

    always @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wptr <= '0;
            rptr <= '0;
            mcnt <= 0;
        end else begin
            if (rdmem_enable) begin
                mem_data_in <= mem[rptr];
                rptr        <= rptr + 3'd1;
            end
            if (push && mcnt < 8) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + 3'd1;
            end
            mcnt <= mcnt + ((push && mcnt < 8) ? 1 : 0) - (rdmem_enable ? 1 : 0);
        end
    end

    // Scoreboard / monitor: compares each accepted word and checks stall stability
    logic [DW-1:0] sb [$];
    int            pops = 0;
    int            cyc  = 0;
    logic          stall_q = 1'b0;
    logic [DW-1:0] stall_data = '0;

    always @(negedge clk) begin
        cyc++;
        if (reset_L) begin
            if (stall_q) begin
                check("stall_hold", {21'd0, valid, data_out}, {21'd0, 1'b1, stall_data});
            end
            if (valid && ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL pop_unexpected: got 0x%0h expected no word", data_out);
                end else begin
                    check("pop_data", {22'd0, data_out}, {22'd0, sb.pop_front()});
                end
                pops++;
            end
            stall_q    = valid && !ready;
            stall_data = data_out;
        end else begin
            stall_q = 1'b0;
        end
    end

    // {rdmem_enable, valid, fifo_count, empty, full, almost_full, almost_empty, error}
    function automatic logic [11:0] pack_out();
        return {rdmem_enable, valid, fifo_count, empty, full, almost_full, almost_empty, error};
    endfunction

    typedef struct {
        logic          push;
        logic [DW-1:0] data;
        logic          ready;
        logic          rden;
        logic          vld;
        logic [3:0]    cnt;
        logic          emp;
        logic          ful;
        logic          af;
        logic          ae;
        logic [1:0]    err;
    } vec_t;

    localparam int NV = 17;
    vec_t vt [NV];

    function automatic vec_t mk(logic p, logic [DW-1:0] d, logic r, logic rd, logic v,
                                logic [3:0] c, logic e, logic f, logic af, logic ae, logic [1:0] er);
        vec_t x;
        x.push = p; x.data = d; x.ready = r; x.rden = rd; x.vld = v; x.cnt = c;
        x.emp = e; x.ful = f; x.af = af; x.ae = ae; x.err = ERR_ON ? er : 2'b00;
        return x;
    endfunction

    function automatic logic [11:0] pack_exp(vec_t x);
        return {x.rden, x.vld, x.cnt, x.emp, x.ful, x.af, x.ae, x.err};
    endfunction

    task automatic drive(input logic p, input logic [DW-1:0] d, input logic r);
        @(posedge clk);
        #1;
        push  = p;
        wdata = d;
        ready = r;
        if (p && mcnt < 8) sb.push_back(d);
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        push    = 1'b0;
        ready   = 1'b0;
        wdata   = '0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 reset_L = 1'b1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            drive(1'b0, '0, 1'b1);
            @(negedge clk);
            #1;
            n++;
        end
        check({name, "_drained"}, sb.size(), 0);
    endtask

    int   p0;
    int   c0;
    int   c1;
    int   n;
    logic found;
    logic [1:0] err_all;

    initial begin
        reset_L = 1'b0;
        push    = 1'b0;
        ready   = 1'b0;
        wdata   = '0;
        err_all = ERR_ON ? 2'b11 : 2'b00;

        // First-word sequence, ready held high (strobe on empty sets underflow)
        vt[0]  = mk(1, 10'h155, 1, 0, 0, 4'd0,  1, 0, 0, 1, 2'b00);
        vt[1]  = mk(0, 10'h000, 1, 1, 0, 4'd1,  0, 0, 0, 1, 2'b10);
        vt[2]  = mk(0, 10'h000, 1, 0, 0, 4'd1,  0, 0, 0, 1, 2'b10);
        vt[3]  = mk(0, 10'h000, 1, 0, 1, 4'd1,  0, 0, 0, 1, 2'b10);
        vt[4]  = mk(0, 10'h000, 1, 0, 0, 4'd0,  1, 0, 0, 1, 2'b10);
        // Fill 0x001..0x00A with ready low, then one overflowing push
        vt[5]  = mk(1, 10'h001, 0, 0, 0, 4'd0,  1, 0, 0, 1, 2'b10);
        vt[6]  = mk(1, 10'h002, 0, 1, 0, 4'd1,  0, 0, 0, 1, 2'b10);
        vt[7]  = mk(1, 10'h003, 0, 1, 0, 4'd2,  0, 0, 0, 0, 2'b10);
        vt[8]  = mk(1, 10'h004, 0, 0, 1, 4'd3,  0, 0, 0, 0, 2'b10);
        vt[9]  = mk(1, 10'h005, 0, 0, 1, 4'd4,  0, 0, 0, 0, 2'b10);
        vt[10] = mk(1, 10'h006, 0, 0, 1, 4'd5,  0, 0, 0, 0, 2'b10);
        vt[11] = mk(1, 10'h007, 0, 0, 1, 4'd6,  0, 0, 0, 0, 2'b10);
        vt[12] = mk(1, 10'h008, 0, 0, 1, 4'd7,  0, 0, 0, 0, 2'b10);
        vt[13] = mk(1, 10'h009, 0, 0, 1, 4'd8,  0, 0, 0, 0, 2'b10);
        vt[14] = mk(1, 10'h00A, 0, 0, 1, 4'd9,  0, 0, 1, 0, 2'b10);
        vt[15] = mk(1, 10'h0AA, 0, 0, 1, 4'd10, 0, 1, 1, 0, 2'b10);
        vt[16] = mk(0, 10'h000, 0, 0, 1, 4'd10, 0, 1, 1, 0, 2'b11);

        // Reset state, then underflow strobing on an empty queue
        do_reset();
        @(negedge clk);
        #1;
        check("reset_state", {20'd0, pack_out()}, {20'd0, 12'b0_0_0000_1_0_0_1_00});
        repeat (3) drive(1'b0, '0, 1'b1);
        @(negedge clk);
        #1;
        check("underflow", {20'd0, pack_out()},
              {20'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, ERR_ON, 1'b0});

        // Table: first word after reset, then fill/stall/overflow
        do_reset();
        for (int i = 0; i < NV; i++) begin
            drive(vt[i].push, vt[i].data, vt[i].ready);
            @(negedge clk);
            #1;
            check($sformatf("vec%0d", i), {20'd0, pack_out()}, {20'd0, pack_exp(vt[i])});
        end

        // Drain the ten stored words; exactly ten must come out
        p0 = pops;
        wait_drain("fill", 40);
        drive(1'b0, '0, 1'b0);
        drive(1'b0, '0, 1'b0);
        @(negedge clk);
        #1;
        check("fill_pops", pops - p0, 10);
        check("fill_idle", {20'd0, pack_out()},
              {20'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, err_all});

        // Streaming 0x010..0x03F with ready high: one word per cycle, no gaps
        p0 = pops;
        c0 = 0;
        c1 = 0;
        fork
            begin : stream_drv
                for (int i = 0; i < 48; i++) drive(1'b1, DW'(16 + i), 1'b1);
                drive(1'b0, '0, 1'b1);
            end
            begin : stream_mon
                n = 0;
                while (pops == p0 && n < 30) begin @(negedge clk); #1; n++; end
                c0 = cyc;
                n = 0;
                while (pops < p0 + 48 && n < 150) begin @(negedge clk); #1; n++; end
                c1 = cyc;
            end
        join
        check("stream_pops", pops - p0, 48);
        check("stream_gapless", c1 - c0, 47);
        wait_drain("stream", 10);

        // Backpressure: ready toggles during a 6-word burst and until drained
        p0 = pops;
        for (int i = 0; i < 6; i++) drive(1'b1, DW'(256 + i), (i % 2) == 0);
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            drive(1'b0, '0, (n % 2) == 1);
            @(negedge clk);
            #1;
            n++;
        end
        check("bp_drained", sb.size(), 0);
        check("bp_pops", pops - p0, 6);

        // Reset asserted in a cycle with a read in flight
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            drive(i < 4, DW'(672 + i), 1'b1);
            @(negedge clk);
            #1;
            if (rdmem_enable && valid) found = 1'b1;
        end
        check("rst_mid_read_seen", {31'd0, found}, 32'd1);
        reset_L = 1'b0;
        push    = 1'b0;
        ready   = 1'b0;
        sb.delete();
        #1;
        check("rst_mid_read_now", {26'd0, valid, fifo_count, rdmem_enable},
              {26'd0, 1'b0, 4'd0, 1'b0});
        @(posedge clk);
        @(posedge clk);
        #1 reset_L = 1'b1;
        repeat (4) drive(1'b0, '0, 1'b0);
        @(negedge clk);
        #1;
        check("rst_mid_read_after", {20'd0, pack_out()}, {20'd0, 12'b0_0_0000_1_0_0_1_00});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_fifo_rd_ctrl
